// File: rtl/pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage
// Description : Pipeline stage register with valid/ready flow control, an
//               optional skid entry, synchronous flush and saturating
//               stall/bubble counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FULL    = 2'd1,
        ST_SKIDDED = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [CTRL_W-1:0] r_out_ctrl;
    logic [DATA_W-1:0] r_out_data;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic w_out_valid;
    logic w_in_ready;
    logic w_accept;
    logic w_issue;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;
    logic w_clr_ctrl;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = in_valid & w_in_ready;
    assign w_issue     = w_out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_ready_skid
            // Registered-only: no combinational path from out_ready.
            assign w_in_ready = (r_state != ST_SKIDDED) & ~flush;
        end else begin : g_ready_noskid
            assign w_in_ready = (~w_out_valid | out_ready) & ~flush;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        w_clr_ctrl       = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt    = ST_FULL;
                    w_load_main_in = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_accept && w_issue) begin
                    w_load_main_in = 1'b1;
                end else if (w_accept) begin
                    // Only reachable with a skid entry; single-entry mode
                    // never accepts while the held entry is stalled.
                    w_state_nxt = ST_SKIDDED;
                    w_load_skid = 1'b1;
                end else if (w_issue) begin
                    w_state_nxt = ST_EMPTY;
                    w_clr_ctrl  = 1'b1;
                end
            end
            ST_SKIDDED: begin
                if (w_issue) begin
                    w_state_nxt      = ST_FULL;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
                w_clr_ctrl  = 1'b1;
            end
        endcase
    end

    generate
        if (SKID != 0) begin : g_skid
            logic [CTRL_W-1:0] r_skid_ctrl;
            logic [DATA_W-1:0] r_skid_data;

            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    r_skid_ctrl <= '0;
                    r_skid_data <= '0;
                end else if (w_load_skid) begin
                    r_skid_ctrl <= in_ctrl;
                    r_skid_data <= in_data;
                end
            end

            assign w_skid_ctrl = r_skid_ctrl;
            assign w_skid_data = r_skid_data;
        end else begin : g_no_skid
            assign w_skid_ctrl = '0;
            assign w_skid_data = '0;
        end
    endgenerate

    // Payload is held on emptying; only control is zeroed so no stale
    // enable can act downstream.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_out_ctrl <= '0;
            r_out_data <= '0;
        end else if (w_load_main_in) begin
            r_out_ctrl <= in_ctrl;
            r_out_data <= in_data;
        end else if (w_load_main_skid) begin
            r_out_ctrl <= w_skid_ctrl;
            r_out_data <= w_skid_data;
        end else if (w_clr_ctrl) begin
            r_out_ctrl <= '0;
        end
    end

    // Counters see the pre-flush outputs, so a flush cycle still counts.
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !out_ready && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            r_bubble_cnt <= '0;
        end else if (!w_out_valid && (r_bubble_cnt != c_cnt_max)) begin
            r_bubble_cnt <= r_bubble_cnt + c_cnt_one;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign out_ctrl   = r_out_ctrl;
    assign out_data   = r_out_data;
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage
// Description : Directed, table-driven bench for pipe_stage (skid and
//               single-entry builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage;

    logic        clk;
    logic        reset;

    // Skid instance stimulus / observation
    logic        s_flush, s_in_valid, s_out_ready, s_cnt_clr;
    logic [7:0]  s_in_ctrl;
    logic [31:0] s_in_data;
    logic        s_in_ready, s_out_valid;
    logic [7:0]  s_out_ctrl;
    logic [31:0] s_out_data;
    logic [3:0]  s_stall_cnt, s_bubble_cnt;

    // Single-entry instance stimulus / observation
    logic        n_flush, n_in_valid, n_out_ready, n_cnt_clr;
    logic [7:0]  n_in_ctrl;
    logic [31:0] n_in_data;
    logic        n_in_ready, n_out_valid;
    logic [7:0]  n_out_ctrl;
    logic [31:0] n_out_data;
    logic [15:0] n_stall_cnt, n_bubble_cnt;

    int n_vec;
    int n_err;

    pipe_stage #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(4)) u_skid (
        .clk        (clk),
        .reset      (reset),
        .flush      (s_flush),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .in_ctrl    (s_in_ctrl),
        .in_data    (s_in_data),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .out_ctrl   (s_out_ctrl),
        .out_data   (s_out_data),
        .cnt_clr    (s_cnt_clr),
        .stall_cnt  (s_stall_cnt),
        .bubble_cnt (s_bubble_cnt)
    );

    pipe_stage #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(16)) u_noskid (
        .clk        (clk),
        .reset      (reset),
        .flush      (n_flush),
        .in_valid   (n_in_valid),
        .in_ready   (n_in_ready),
        .in_ctrl    (n_in_ctrl),
        .in_data    (n_in_data),
        .out_valid  (n_out_valid),
        .out_ready  (n_out_ready),
        .out_ctrl   (n_out_ctrl),
        .out_data   (n_out_data),
        .cnt_clr    (n_cnt_clr),
        .stall_cnt  (n_stall_cnt),
        .bubble_cnt (n_bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        fl;
        logic        iv;
        logic [7:0]  ic;
        logic [31:0] id;
        logic        ordy;
        logic        ir;
        logic        ov;
        logic [7:0]  oc;
        logic [31:0] od;
        logic [3:0]  st;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int fl, input int iv, input int ic, input int id,
                                input int ordy, input int ir, input int ov, input int oc,
                                input int od, input int st);
        vec_t v;
        v.fl   = fl[0];
        v.iv   = iv[0];
        v.ic   = ic[7:0];
        v.id   = id;
        v.ordy = ordy[0];
        v.ir   = ir[0];
        v.ov   = ov[0];
        v.oc   = oc[7:0];
        v.od   = od;
        v.st   = st[3:0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // Streaming: 10 back-to-back entries, one-cycle latency, no stalls
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, 1, 'h10 + i, i, 1, 1, (i > 0) ? 1 : 0,
                             (i > 0) ? ('h10 + i - 1) : 0, (i > 0) ? (i - 1) : 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1,     1, 1, 'h19, 9, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1,     1, 0, 0,    9, 0));
        // Backpressure: A on output, B skidded, C held upstream
        tbl.push_back(mk(0, 1, 'hA1, 'hA, 1, 1, 0, 0,     9,   0));
        tbl.push_back(mk(0, 1, 'hB1, 'hB, 0, 1, 1, 'hA1, 'hA, 0));
        tbl.push_back(mk(0, 1, 'hC1, 'hC, 0, 0, 1, 'hA1, 'hA, 1));
        tbl.push_back(mk(0, 1, 'hC1, 'hC, 0, 0, 1, 'hA1, 'hA, 2));
        tbl.push_back(mk(0, 1, 'hC1, 'hC, 1, 0, 1, 'hA1, 'hA, 3));
        tbl.push_back(mk(0, 1, 'hC1, 'hC, 1, 1, 1, 'hB1, 'hB, 3));
        tbl.push_back(mk(0, 0, 0,     0,  1, 1, 1, 'hC1, 'hC, 3));
        tbl.push_back(mk(0, 0, 0,     0,  1, 1, 0, 0,    'hC, 3));
        // Flush while SKIDDED with a live input
        tbl.push_back(mk(0, 1, 'hD1, 'hD,  0, 1, 0, 0,    'hC, 3));
        tbl.push_back(mk(0, 1, 'hE1, 'hE,  0, 1, 1, 'hD1, 'hD, 3));
        tbl.push_back(mk(1, 1, 'h07, 'h77, 0, 0, 1, 'hD1, 'hD, 4));
        tbl.push_back(mk(0, 0, 0,     0,   1, 1, 0, 0,    0,   5));
        tbl.push_back(mk(0, 1, 'hF1, 'hF,  1, 1, 0, 0,    0,   5));
        tbl.push_back(mk(0, 0, 0,     0,   1, 1, 1, 'hF1, 'hF, 5));
        tbl.push_back(mk(0, 0, 0,     0,   1, 1, 0, 0,    'hF, 5));

        // Reset held two edges with a live, all-ones input
        reset       = 1'b1;
        s_flush     = 1'b0; s_in_valid = 1'b1; s_in_ctrl = 8'hFF; s_in_data = 32'hFFFF_FFFF;
        s_out_ready = 1'b1; s_cnt_clr  = 1'b0;
        n_flush     = 1'b0; n_in_valid = 1'b1; n_in_ctrl = 8'hFF; n_in_data = 32'hFFFF_FFFF;
        n_out_ready = 1'b1; n_cnt_clr  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset      = 1'b0;
        s_in_valid = 1'b0; s_in_ctrl = 8'h00; s_in_data = '0;
        n_in_valid = 1'b0; n_in_ctrl = 8'h00; n_in_data = '0;
        #1;
        chk("rst s in_ready",   64'(s_in_ready),   64'd1);
        chk("rst s out_valid",  64'(s_out_valid),  64'd0);
        chk("rst s out_ctrl",   64'(s_out_ctrl),   64'd0);
        chk("rst s out_data",   64'(s_out_data),   64'd0);
        chk("rst s stall_cnt",  64'(s_stall_cnt),  64'd0);
        chk("rst s bubble_cnt", 64'(s_bubble_cnt), 64'd0);
        chk("rst n in_ready",   64'(n_in_ready),   64'd1);
        chk("rst n out_valid",  64'(n_out_valid),  64'd0);
        @(negedge clk);
        #1;
        chk("post-rst s out_valid", 64'(s_out_valid), 64'd0);

        // Table: inputs applied, current-cycle outputs compared, then clocked
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            s_flush     = tbl[i].fl;
            s_in_valid  = tbl[i].iv;
            s_in_ctrl   = tbl[i].ic;
            s_in_data   = tbl[i].id;
            s_out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("v%0d in_ready", i),  64'(s_in_ready),  64'(tbl[i].ir));
            chk($sformatf("v%0d out_valid", i), 64'(s_out_valid), 64'(tbl[i].ov));
            chk($sformatf("v%0d out_ctrl", i),  64'(s_out_ctrl),  64'(tbl[i].oc));
            chk($sformatf("v%0d out_data", i),  64'(s_out_data),  64'(tbl[i].od));
            chk($sformatf("v%0d stall_cnt", i), 64'(s_stall_cnt), 64'(tbl[i].st));
        end

        // Counter saturation at 4 bits, then clear-over-increment
        s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
        s_cnt_clr = 1'b1;
        @(negedge clk);
        s_cnt_clr = 1'b0;
        #1;
        chk("clr bubble_cnt", 64'(s_bubble_cnt), 64'd0);
        chk("clr stall_cnt",  64'(s_stall_cnt),  64'd0);
        repeat (14) @(negedge clk);
        #1;
        chk("bubble 14", 64'(s_bubble_cnt), 64'd14);
        @(negedge clk);
        #1;
        chk("bubble 15", 64'(s_bubble_cnt), 64'd15);
        repeat (5) @(negedge clk);
        #1;
        chk("bubble sat", 64'(s_bubble_cnt), 64'd15);
        s_cnt_clr = 1'b1;
        @(negedge clk);
        s_cnt_clr = 1'b0;
        #1;
        chk("bubble clr idle", 64'(s_bubble_cnt), 64'd0);
        @(negedge clk);
        #1;
        chk("bubble after clr", 64'(s_bubble_cnt), 64'd1);

        // Single-entry: combinational out_ready -> in_ready
        @(negedge clk);
        n_in_valid = 1'b1; n_in_ctrl = 8'h51; n_in_data = 32'h51; n_out_ready = 1'b1;
        #1;
        chk("n0 in_ready",  64'(n_in_ready),  64'd1);
        chk("n0 out_valid", 64'(n_out_valid), 64'd0);
        @(negedge clk);
        n_in_ctrl = 8'h52; n_in_data = 32'h52; n_out_ready = 1'b0;
        #1;
        chk("n1 in_ready",  64'(n_in_ready),  64'd0);
        chk("n1 out_valid", 64'(n_out_valid), 64'd1);
        chk("n1 out_data",  64'(n_out_data),  64'h51);
        n_out_ready = 1'b1;
        #1;
        chk("n1 in_ready toggle", 64'(n_in_ready), 64'd1);
        @(negedge clk);
        n_in_valid = 1'b0;
        #1;
        chk("n2 out_valid", 64'(n_out_valid), 64'd1);
        chk("n2 out_ctrl",  64'(n_out_ctrl),  64'h52);
        chk("n2 out_data",  64'(n_out_data),  64'h52);
        @(negedge clk);
        n_flush = 1'b1; n_in_valid = 1'b1; n_in_ctrl = 8'h07; n_in_data = 32'h77;
        #1;
        chk("n3 out_valid", 64'(n_out_valid), 64'd0);
        chk("n3 out_ctrl",  64'(n_out_ctrl),  64'd0);
        chk("n3 out_data",  64'(n_out_data),  64'h52);
        chk("n3 flush in_ready", 64'(n_in_ready), 64'd0);
        @(negedge clk);
        n_flush = 1'b0; n_in_valid = 1'b0;
        #1;
        chk("n4 out_valid", 64'(n_out_valid), 64'd0);
        chk("n4 out_data",  64'(n_out_data),  64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage.md
# pipe_stage

Parametrised pipeline stage register with valid/ready flow control, an optional skid entry, synchronous flush and saturating stall/bubble counters. It generalises the fixed EX/MEM register: the control and payload buses are packed vectors of configurable width, and backpressure holds data instead of zeroing it. Flush inserts a bubble. One instance sits between each pair of core pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- DATA_W, 128: payload width (pc, inst, alu_out, rdata2 … packed by the instantiating stage)
- CTRL_W, 8: control width (rd_en, wr_en, reg_wr, sel_dm …); every bit active-high
- SKID, 1: 1 = two-entry (main + skid), in_ready registered; 0 = single entry, in_ready combinational
- CNT_W, 16: counter width
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous kill of all held entries (branch/exception redirect)
- in_valid  in  1  upstream has an entry
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  upstream control
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  out_ctrl/out_data hold a live entry
- out_ready  in  1  downstream consumes this cycle
- out_ctrl  out  CTRL_W  registered control, all-zero whenever out_valid=0
- out_data  out  DATA_W  registered payload
- cnt_clr  in  1  synchronous clear of both counters
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
- bubble_cnt  out  CNT_W  cycles with out_valid=0

## Operation
- accept = in_valid & in_ready; issue = out_valid & out_ready.
- in_ready: SKID=1 -> !skid_valid & !flush; SKID=0 -> (!out_valid | out_ready) & !flush.
- States (SKID=1): EMPTY (out_valid=0), FULL (main live, skid empty), SKIDDED (both live).
  - EMPTY: accept -> FULL, main<=in.
  - FULL: accept&issue -> FULL, main<=in; accept&!issue -> SKIDDED, skid<=in; !accept&issue -> EMPTY; else hold.
  - SKIDDED: issue -> FULL, main<=skid; else hold; in_ready=0.
- SKID=0: EMPTY/FULL only, same transitions minus SKIDDED.
- Entering EMPTY clears out_ctrl to 0; out_data keeps its last value.
- Order preserved: the skid entry always issues after the main entry.
- Priority: reset > flush > normal transfer.
- flush: out_valid<=0, skid_valid<=0, out_ctrl<=0, out_data<=0; state -> EMPTY; in_valid on a flush cycle is not accepted. Counters unaffected.
- Counters: +1 per qualifying cycle, saturate at 2^CNT_W−1, no wrap. cnt_clr zeroes both and takes priority over increment. A flush cycle counts per pre-flush out_valid/out_ready.

## Timing
- Reset values: out_valid=0, skid_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, bubble_cnt=0. in_ready=1 the cycle after reset deasserts.
- Latency: accept at edge N -> out_valid=1 with that entry after edge N (visible cycle N+1).
- Throughput: one entry per cycle while out_ready=1, both modes.
- SKID=1: in_ready depends only on registered state and flush. No comb path from out_ready to in_ready.
- SKID=0: comb path out_ready -> in_ready (documented; used only in short stages).
- After out_ready drops, in_ready falls one cycle later (SKID=1). Exactly one extra entry is absorbed, never lost.
- Reset or flush mid-SKIDDED discards both entries, with no issue on that edge.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1, in_ctrl=8'hFF -> all outputs 0, in_ready=1 first cycle after reset; out_valid stays 0.
- Streaming: out_ready=1, 10 back-to-back entries data=0..9 -> out_data 0..9 on consecutive cycles, 1-cycle latency, stall_cnt=0.
- Backpressure (SKID=1): stream A,B,C; drop out_ready while A on output -> B captured in skid, in_ready=0 next cycle, C held upstream; raise out_ready -> A,B,C emitted in order, none duplicated; stall_cnt = stalled cycles.
- Flush in SKIDDED with in_valid=1 (ctrl=8'h07) -> next cycle out_valid=0, out_ctrl=0, out_data=0, input not accepted; following entry passes normally.
- Counter saturation (CNT_W=4): 20 idle cycles -> bubble_cnt=15 and holds; cnt_clr together with idle -> 0.
- SKID=0: out_valid=1, out_ready=0 -> in_ready=0 same cycle; toggle out_ready=1 -> in_ready=1 same cycle, simultaneous accept+issue keeps out_valid=1.
